// File: rtl/fpu_pkg.sv
// Shared FPU types: rounding modes, sqrt FSM states, exception flags and
// the canonical quiet-NaN mantissa used by every format.
package fpu;

  typedef enum logic [1:0] {EVEN, DOWN, UP, ZERO} fpu_round_mode_t;

  typedef enum logic [2:0] {IDLE, PREP, ITER, ROUND, DONE} fpu_sqrt_state_t;

  typedef struct packed {
    logic invalid;
    logic inexact;
  } fpu_flags_t;

  localparam int FPU_MAX_MANT = 64;

  // Quiet-NaN mantissa for a format: MSB set, rest clear. Callers truncate.
  function automatic logic [FPU_MAX_MANT-1:0] fpu_qnan_mant(input int unsigned mant_w);
    fpu_qnan_mant = FPU_MAX_MANT'(1) << (mant_w - 1);
  endfunction

endpackage

// File: rtl/fpu_sqrt_step.sv
// One restoring radix-2 square-root iteration (purely combinational).
module fpu_sqrt_step #(
  parameter int ROOT_W = 26
) (
  input  logic [ROOT_W+1:0] rem,
  input  logic [ROOT_W-1:0] root,
  input  logic [1:0]        bits,
  output logic [ROOT_W+1:0] rem_nxt,
  output logic [ROOT_W-1:0] root_nxt
);

  logic [ROOT_W+1:0] rem_sh;
  logic [ROOT_W+2:0] trial;
  logic              ok;

  // The remainder never exceeds 2*root, so its top two bits are always
  // zero here and can be shifted out.
  assign rem_sh   = (ROOT_W+2)'({rem, bits});
  assign trial    = {1'b0, rem_sh} - {1'b0, root, 2'b01};
  assign ok       = ~trial[ROOT_W+2];
  assign rem_nxt  = ok ? trial[ROOT_W+1:0] : rem_sh;
  assign root_nxt = ROOT_W'({root, ok});

endmodule

// File: rtl/fpu_sqrt_seq.sv
// Iterative IEEE-754 square root, any exponent/mantissa width, one root
// bit per cycle, valid/ready on both sides, all four rounding modes.
module fpu_sqrt_seq
  import fpu::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [EXP_WIDTH-1:0]  in_exponent,
  input  logic [MANT_WIDTH-1:0] in_mantissa,
  input  fpu_round_mode_t       in_round_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic [EXP_WIDTH-1:0]  out_exponent,
  output logic [MANT_WIDTH-1:0] out_mantissa,
  output logic                  out_invalid,
  output logic                  out_inexact
);

  localparam int N      = MANT_WIDTH + 3;
  localparam int SW     = MANT_WIDTH + 1;
  localparam int RW     = N + 2;
  localparam int EW     = EXP_WIDTH + 2;
  localparam int CW     = $clog2(N + 1);
  localparam int LW     = $clog2(SW + 1);
  localparam int BIAS_I = (1 << (EXP_WIDTH - 1)) - 1;
  localparam logic signed [EW-1:0] BIAS = EW'(BIAS_I);
  localparam logic [MANT_WIDTH-1:0] QNAN_MANT = MANT_WIDTH'(fpu_qnan_mant(MANT_WIDTH));

  fpu_sqrt_state_t        state;
  logic                   sign_q;
  logic [EXP_WIDTH-1:0]   exp_q;
  logic [MANT_WIDTH-1:0]  mant_q;
  fpu_round_mode_t        rm_q;
  logic [2*N-1:0]         rad_q;
  logic [RW-1:0]          rem_q;
  logic [N-1:0]           root_q;
  logic [CW-1:0]          cnt_q;
  logic signed [EW-1:0]   rexp_q;

  logic [RW-1:0]          rem_nxt;
  logic [N-1:0]           root_nxt;

  fpu_sqrt_step #(.ROOT_W(N)) u_step (
    .rem      (rem_q),
    .root     (root_q),
    .bits     (rad_q[2*N-1 -: 2]),
    .rem_nxt  (rem_nxt),
    .root_nxt (root_nxt)
  );

  assign in_ready = (state == IDLE) & ~rst;

  // Operand classification and normalisation
  logic exp_ones, exp_zero, mant_zero, is_nan, is_snan, is_zero, is_inf;
  assign exp_ones  = &exp_q;
  assign exp_zero  = ~|exp_q;
  assign mant_zero = ~|mant_q;
  assign is_nan    = exp_ones & ~mant_zero;
  assign is_snan   = is_nan & ~mant_q[MANT_WIDTH-1];
  assign is_zero   = exp_zero & mant_zero;
  assign is_inf    = exp_ones & mant_zero;

  logic [SW-1:0]        sig_raw, sig_norm;
  logic [LW-1:0]        lz;
  logic                 lz_found;
  logic signed [EW-1:0] e_pre, e_adj, rexp_init;
  logic [2*N-1:0]       rad_init;

  assign sig_raw = {~exp_zero, mant_q};

  always_comb begin
    lz       = '0;
    lz_found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!lz_found) begin
        if (sig_raw[i]) lz_found = 1'b1;
        else            lz       = lz + LW'(1);
      end
    end
  end

  assign sig_norm  = sig_raw << lz;
  assign e_pre     = exp_zero ? (EW'(1) - BIAS - signed'(EW'(lz)))
                              : (signed'(EW'(exp_q)) - BIAS);
  assign e_adj     = e_pre - signed'(EW'(e_pre[0]));
  assign rexp_init = (e_adj >>> 1) + BIAS;
  // Radicand is aligned so the root's top bit is the integer bit; an odd
  // exponent moves one factor of two into the radicand.
  assign rad_init  = e_pre[0] ? {sig_norm, {(MANT_WIDTH+5){1'b0}}}
                              : {1'b0, sig_norm, {(MANT_WIDTH+4){1'b0}}};

  // Rounding of the finished root: root = {significand, guard, round}
  logic          guard, sticky, lsb, rnd_up, carry;
  logic [SW:0]   sig_r;
  assign guard  = root_q[1];
  assign sticky = (|rem_q) | root_q[0];
  assign lsb    = root_q[2];

  always_comb begin
    rnd_up = 1'b0;
    case (rm_q)
      EVEN:    rnd_up = guard & (sticky | lsb);
      UP:      rnd_up = guard | sticky;
      default: rnd_up = 1'b0;
    endcase
  end

  assign sig_r = {1'b0, root_q[N-1:2]} + (SW+1)'(rnd_up);
  assign carry = sig_r[SW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      out_valid    <= 1'b0;
      out_sign     <= 1'b0;
      out_exponent <= '0;
      out_mantissa <= '0;
      out_invalid  <= 1'b0;
      out_inexact  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign_q <= in_sign;
          exp_q  <= in_exponent;
          mant_q <= in_mantissa;
          rm_q   <= in_round_mode;
          state  <= PREP;
        end
        PREP: begin
          out_inexact <= 1'b0;
          out_invalid <= 1'b0;
          if (is_nan || (sign_q && !is_zero)) begin
            out_sign     <= 1'b0;
            out_exponent <= '1;
            out_mantissa <= QNAN_MANT;
            out_invalid  <= is_nan ? is_snan : 1'b1;
            out_valid    <= 1'b1;
            state        <= DONE;
          end else if (is_zero || is_inf) begin
            out_sign     <= sign_q;
            out_exponent <= exp_q;
            out_mantissa <= '0;
            out_valid    <= 1'b1;
            state        <= DONE;
          end else begin
            rad_q  <= rad_init;
            rexp_q <= rexp_init;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            state  <= ITER;
          end
        end
        ITER: begin
          rem_q  <= rem_nxt;
          root_q <= root_nxt;
          rad_q  <= rad_q << 2;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) state <= ROUND;
        end
        ROUND: begin
          out_sign     <= 1'b0;
          out_exponent <= EXP_WIDTH'(rexp_q + signed'(EW'(carry)));
          out_mantissa <= carry ? '0 : MANT_WIDTH'(sig_r);
          out_invalid  <= 1'b0;
          out_inexact  <= guard | sticky;
          out_valid    <= 1'b1;
          state        <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
